// File: rtl/ahb_lite_master_bridge.sv
// Single-transfer AHB-Lite initiator: one valid/ready command becomes one NONSEQ SINGLE
// transfer, and each command gets exactly one response pulse with error and wait-state info.
module ahb_lite_master_bridge #(
    parameter int unsigned WAIT_WIDTH  = 8,
    parameter logic [3:0]  HPROT_VALUE = 4'b0011
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic                  cmd_write,
    input  logic [31:0]           cmd_addr,
    input  logic [2:0]            cmd_size,
    input  logic [31:0]           cmd_wdata,
    output logic                  rsp_valid,
    output logic                  rsp_err,
    output logic [31:0]           rsp_rdata,
    output logic [WAIT_WIDTH-1:0] rsp_wait,
    output logic [31:0]           HADDR,
    output logic [1:0]            HTRANS,
    output logic                  HWRITE,
    output logic [2:0]            HSIZE,
    output logic [2:0]            HBURST,
    output logic [3:0]            HPROT,
    output logic                  HMASTLOCK,
    output logic [31:0]           HWDATA,
    input  logic                  HREADY,
    input  logic                  HRESP,
    input  logic [31:0]           HRDATA
);
    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_DATA, S_ERR, S_REJ} state_e;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

    state_e                state_q, state_d;
    logic [1:0]            htrans_q, htrans_d;
    logic [31:0]           haddr_q, haddr_d;
    logic                  hwrite_q, hwrite_d;
    logic [2:0]            hsize_q, hsize_d;
    logic [31:0]           hwdata_q, hwdata_d;
    logic [WAIT_WIDTH-1:0] wait_cnt_q, wait_cnt_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic                  rsp_err_q, rsp_err_d;
    logic [31:0]           rsp_rdata_q, rsp_rdata_d;
    logic [WAIT_WIDTH-1:0] rsp_wait_q, rsp_wait_d;
    logic                  cmd_illegal;

    // Sizes above a word, or addresses not aligned to the transfer size, never reach the bus.
    assign cmd_illegal = (cmd_size > 3'd2)
                      || ((cmd_size == 3'd1) && cmd_addr[0])
                      || ((cmd_size == 3'd2) && (cmd_addr[1:0] != 2'b00));

    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_d     = state_q;
        haddr_d     = haddr_q;
        hwrite_d    = hwrite_q;
        hsize_d     = hsize_q;
        hwdata_d    = hwdata_q;
        wait_cnt_d  = wait_cnt_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_wait_d  = rsp_wait_q;

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    haddr_d  = cmd_addr;
                    hwrite_d = cmd_write;
                    hsize_d  = cmd_size;
                    hwdata_d = cmd_wdata;
                    if (cmd_illegal) begin
                        state_d     = S_REJ;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_rdata_d = '0;
                        rsp_wait_d  = '0;
                    end else begin
                        state_d = S_ADDR;
                    end
                end
            end
            S_REJ: state_d = S_IDLE;
            S_ADDR: begin
                if (HREADY) begin
                    state_d    = S_DATA;
                    wait_cnt_d = '0;
                end
            end
            S_DATA: begin
                if (!HREADY) begin
                    if (wait_cnt_q != '1) wait_cnt_d = wait_cnt_q + WAIT_WIDTH'(1);
                    if (HRESP) state_d = S_ERR;
                end else begin
                    // HRESP with HREADY high and no first ERROR cycle is still reported as an error.
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = HRESP;
                    rsp_rdata_d = (!HRESP && !hwrite_q) ? HRDATA : '0;
                    rsp_wait_d  = wait_cnt_q;
                end
            end
            S_ERR: begin
                if (HREADY) begin
                    state_d     = S_IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_wait_d  = wait_cnt_q;
                end
            end
            default: state_d = S_IDLE;
        endcase

        htrans_d = (state_d == S_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
    end

    // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state_q     <= S_IDLE;
            htrans_q    <= HTRANS_IDLE;
            haddr_q     <= '0;
            hwrite_q    <= 1'b0;
            hsize_q     <= '0;
            hwdata_q    <= '0;
            wait_cnt_q  <= '0;
            rsp_valid_q <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_wait_q  <= '0;
        end else begin
            state_q     <= state_d;
            htrans_q    <= htrans_d;
            haddr_q     <= haddr_d;
            hwrite_q    <= hwrite_d;
            hsize_q     <= hsize_d;
            hwdata_q    <= hwdata_d;
            wait_cnt_q  <= wait_cnt_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_wait_q  <= rsp_wait_d;
        end
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_wait  = rsp_wait_q;
    assign HADDR     = haddr_q;
    assign HTRANS    = htrans_q;
    assign HWRITE    = hwrite_q;
    assign HSIZE     = hsize_q;
    assign HBURST    = 3'b000;
    assign HPROT     = HPROT_VALUE;
    assign HMASTLOCK = 1'b0;
    assign HWDATA    = hwdata_q;
endmodule

// File: tb/tb_ahb_lite_master_bridge.sv
// Scoreboard bench: two bridges (8-bit and 2-bit wait counters) share one stimulus stream;
// each command pushes the expected response, a negedge monitor pops and compares.
module tb_ahb_lite_master_bridge;
    logic        HCLK = 1'b0;
    logic        HRESET;
    logic        cmd_valid, cmd_write;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [2:0]  cmd_size;
    logic        HREADY, HRESP;
    logic [31:0] HRDATA;

    logic        cmd_ready, rsp_valid, rsp_err, HWRITE, HMASTLOCK;
    logic [31:0] rsp_rdata, HADDR, HWDATA;
    logic [7:0]  rsp_wait;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;

    logic        w2_cmd_ready, w2_rsp_valid, w2_rsp_err, w2_hwrite, w2_hmastlock;
    logic [31:0] w2_rsp_rdata, w2_haddr, w2_hwdata;
    logic [1:0]  w2_rsp_wait, w2_htrans;
    logic [2:0]  w2_hsize, w2_hburst;
    logic [3:0]  w2_hprot;

    typedef struct {
        logic        err;
        logic [31:0] rdata;
        logic [7:0]  wait8;
        logic [1:0]  wait2;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 HCLK = ~HCLK;

    ahb_lite_master_bridge #(.WAIT_WIDTH(8)) dut (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_rdata(rsp_rdata), .rsp_wait(rsp_wait),
        .HADDR(HADDR), .HTRANS(HTRANS), .HWRITE(HWRITE), .HSIZE(HSIZE), .HBURST(HBURST),
        .HPROT(HPROT), .HMASTLOCK(HMASTLOCK), .HWDATA(HWDATA),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    ahb_lite_master_bridge #(.WAIT_WIDTH(2)) dut_w2 (
        .HCLK(HCLK), .HRESET(HRESET),
        .cmd_valid(cmd_valid), .cmd_ready(w2_cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
        .rsp_valid(w2_rsp_valid), .rsp_err(w2_rsp_err), .rsp_rdata(w2_rsp_rdata),
        .rsp_wait(w2_rsp_wait),
        .HADDR(w2_haddr), .HTRANS(w2_htrans), .HWRITE(w2_hwrite), .HSIZE(w2_hsize),
        .HBURST(w2_hburst), .HPROT(w2_hprot), .HMASTLOCK(w2_hmastlock), .HWDATA(w2_hwdata),
        .HREADY(HREADY), .HRESP(HRESP), .HRDATA(HRDATA)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    // Response monitor: every rsp_valid pulse must match the oldest outstanding expectation.
    always @(negedge HCLK) begin
        if (rsp_valid || w2_rsp_valid) begin
            check("rsp_valid_w2", {31'd0, w2_rsp_valid}, {31'd0, rsp_valid});
            if (sb.size() == 0) begin
                check("spurious_rsp", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                check("rsp_rdata", rsp_rdata, e.rdata);
                check("rsp_wait", {24'd0, rsp_wait}, {24'd0, e.wait8});
                check("rsp_err_w2", {31'd0, w2_rsp_err}, {31'd0, e.err});
                check("rsp_rdata_w2", w2_rsp_rdata, e.rdata);
                check("rsp_wait_w2", {30'd0, w2_rsp_wait}, {30'd0, e.wait2});
            end
        end
    end

    // err_mode: 0 = OKAY, 1 = two-cycle ERROR, 2 = single-cycle ERROR (protocol violation).
    task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                        input logic [31:0] wdata, input int addr_waits, input int data_waits,
                        input int err_mode, input logic [31:0] rdata);
        exp_t e;
        logic illegal;
        int   w;
        illegal = (size > 3'd2) || (size == 3'd1 && addr[0]) || (size == 3'd2 && addr[1:0] != 2'b00);
        w       = data_waits + ((err_mode == 1) ? 1 : 0);
        e.err   = illegal || (err_mode != 0);
        e.rdata = (!illegal && !wr && err_mode == 0) ? rdata : 32'd0;
        e.wait8 = illegal ? 8'd0 : ((w > 255) ? 8'd255 : 8'(w));
        e.wait2 = illegal ? 2'd0 : ((w > 3) ? 2'd3 : 2'(w));
        sb.push_back(e);

        check("cmd_ready_idle", {31'd0, cmd_ready}, 32'd1);
        cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_size = size; cmd_wdata = wdata;
        HREADY = 1'b1; HRESP = 1'b0; HRDATA = 32'hBAD0_0000 ^ rdata;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        if (illegal) begin
            check("rej_htrans", {30'd0, HTRANS}, 32'd0);
            check("rej_rsp_valid", {31'd0, rsp_valid}, 32'd1);
            check("rej_cmd_ready", {31'd0, cmd_ready}, 32'd0);
            @(posedge HCLK); #1;
            check("rej_htrans_after", {30'd0, HTRANS}, 32'd0);
            return;
        end
        check("addr_htrans", {30'd0, HTRANS}, 32'h2);
        check("addr_haddr", HADDR, addr);
        check("addr_hwrite", {31'd0, HWRITE}, {31'd0, wr});
        check("addr_hsize", {29'd0, HSIZE}, {29'd0, size});
        for (int i = 0; i < addr_waits; i++) begin
            HREADY = 1'b0;
            @(posedge HCLK); #1;
            check("addr_wait_htrans", {30'd0, HTRANS}, 32'h2);
        end
        HREADY = 1'b1;
        @(posedge HCLK); #1;
        check("data_htrans", {30'd0, HTRANS}, 32'd0);
        check("data_hwdata", HWDATA, wdata);
        for (int i = 0; i < data_waits; i++) begin
            HREADY = 1'b0; HRESP = 1'b0;
            @(posedge HCLK); #1;
            check("data_wait_hwdata", HWDATA, wdata);
            check("data_wait_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        end
        HRDATA = rdata;
        if (err_mode == 1) begin
            HREADY = 1'b0; HRESP = 1'b1;
            @(posedge HCLK); #1;
            HREADY = 1'b1; HRESP = 1'b1;
        end else if (err_mode == 2) begin
            HREADY = 1'b1; HRESP = 1'b1;
        end else begin
            HREADY = 1'b1; HRESP = 1'b0;
        end
        @(posedge HCLK); #1;
        HRESP = 1'b0; HRDATA = 32'h5555_AAAA;
        check("done_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("done_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_cmd_ready"}, {31'd0, cmd_ready}, 32'd1);
        check({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        check({tag, "_htrans"}, {30'd0, HTRANS}, 32'd0);
        check({tag, "_haddr"}, HADDR, 32'd0);
        check({tag, "_hwdata"}, HWDATA, 32'd0);
        check({tag, "_hwrite_hsize"}, {28'd0, HWRITE, HSIZE}, 32'd0);
        check({tag, "_rsp_fields"}, {rsp_rdata[31:1] | {23'd0, rsp_wait}, rsp_err}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        HRESET = 1'b1; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_size = '0;
        cmd_wdata = '0; HREADY = 1'b1; HRESP = 1'b0; HRDATA = '0;
        repeat (2) @(posedge HCLK);
        #1 HRESET = 1'b0;
        check_reset_state("reset");
        check("hburst", {29'd0, HBURST}, 32'd0);
        check("hprot", {28'd0, HPROT}, 32'h3);
        check("hmastlock", {31'd0, HMASTLOCK}, 32'd0);

        xfer(1'b0, 32'h0000_0010, 3'd2, 32'h0,          0, 0, 0, 32'hDEAD_BEEF);
        xfer(1'b1, 32'h0000_0004, 3'd2, 32'h1234_5678,  0, 3, 0, 32'h0BAD_F00D);
        xfer(1'b0, 32'h0000_0020, 3'd2, 32'h0,          0, 0, 1, 32'hCAFE_0001);
        xfer(1'b0, 32'h0000_0024, 3'd2, 32'h0,          1, 1, 2, 32'hCAFE_0002);
        xfer(1'b0, 32'h0000_0002, 3'd2, 32'h0,          0, 0, 0, 32'h1111_1111);
        xfer(1'b1, 32'h0000_0008, 3'd3, 32'hFFFF_0000,  0, 0, 0, 32'h0);
        xfer(1'b0, 32'h0000_0031, 3'd1, 32'h0,          0, 0, 0, 32'h2222_2222);
        xfer(1'b0, 32'h0000_0033, 3'd0, 32'h0,          2, 2, 0, 32'h0000_00A5);
        xfer(1'b0, 32'h0000_0042, 3'd1, 32'h0,          0, 6, 0, 32'h0000_5A5A);
        xfer(1'b1, 32'h0000_0100, 3'd2, 32'hA5A5_A5A5,  0, 260, 0, 32'h0);

        // Reset while the data phase is stalled: the transfer is abandoned with no response.
        cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 32'h0000_0200; cmd_size = 3'd2;
        HREADY = 1'b1;
        @(posedge HCLK); #1;
        cmd_valid = 1'b0;
        @(posedge HCLK); #1;
        HREADY = 1'b0;
        @(posedge HCLK); #1;
        HRESET = 1'b1;
        @(posedge HCLK); #1;
        HRESET = 1'b0; HREADY = 1'b1;
        check_reset_state("midreset");
        repeat (5) @(posedge HCLK);
        #1;

        xfer(1'b0, 32'h0000_0300, 3'd2, 32'h0, 0, 0, 0, 32'h7777_8888);
        repeat (3) @(posedge HCLK);
        check("sb_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/ahb_lite_master_bridge.md
# ahb_lite_master_bridge

Single-transfer AHB-Lite initiator that turns a simple valid/ready command port into one AHB-Lite NONSEQ SINGLE transfer at a time. It sits upstream of the address decoder and the slave response multiplexer, and drives the shared HADDR/HTRANS/HWDATA bus. It consumes the multiplexed HREADY/HRESP/HRDATA and returns one response per command, with error and wait-state information.

## Interface
- WAIT_WIDTH, 8: width of the saturating wait-state counter reported with each response.
- HPROT_VALUE, 4'b0011: constant driven on HPROT (non-cacheable, non-bufferable, privileged, data).
- HCLK  in  1  bus clock; all logic on rising edge.
- HRESET  in  1  synchronous, active-high reset.
- cmd_valid  in  1  command present.
- cmd_ready  out  1  bridge accepts command this cycle.
- cmd_write  in  1  1 = write, 0 = read.
- cmd_addr  in  32  byte address.
- cmd_size  in  3  AHB HSIZE encoding; only 0/1/2 legal.
- cmd_wdata  in  32  write data.
- rsp_valid  out  1  one-cycle response pulse; no backpressure.
- rsp_err  out  1  transfer ended in ERROR or was rejected locally.
- rsp_rdata  out  32  read data; 0 for writes and errors.
- rsp_wait  out  WAIT_WIDTH  data-phase cycles with HREADY low, saturating.
- HADDR  out  32, HTRANS  out  2, HWRITE  out  1, HSIZE  out  3, HBURST  out  3 (always 3'b000), HPROT  out  4, HMASTLOCK  out  1 (always 0), HWDATA  out  32.
- HREADY  in  1, HRESP  in  1, HRDATA  in  32  multiplexed slave response.

## Operation
- States: IDLE, ADDR, DATA, ERR, REJ.
- IDLE: cmd_ready=1, HTRANS=IDLE (2'b00). On cmd_valid, latch write/addr/size/wdata.
  - If legal, go to ADDR.
  - Go to REJ instead if cmd_size>2, size 1 with addr[0]=1, or size 2 with addr[1:0]≠0.
- REJ: no bus activity. Next edge: rsp_valid=1, rsp_err=1, rsp_wait=0. Return to IDLE.
- ADDR: HTRANS=NONSEQ (2'b10); HADDR/HWRITE/HSIZE from latched values. Stay while HREADY=0. On HREADY=1, go to DATA.
- DATA: HTRANS=IDLE; HWDATA holds latched wdata for the whole state (also for reads). Wait counter starts at 0.
  - HREADY=0, HRESP=0: increment counter (saturate at 2^WAIT_WIDTH−1).
  - HREADY=0, HRESP=1: first ERROR cycle. Increment counter, go to ERR.
  - HREADY=1, HRESP=0: next edge rsp_valid=1, rsp_err=0, rsp_rdata=HRDATA if read else 0, rsp_wait=counter. Go to IDLE.
  - HREADY=1, HRESP=1 without a preceding HREADY=0 cycle is a protocol violation. Treat it as an error completion: rsp_err=1, rsp_rdata=0.
- ERR: wait for HREADY=1 (second ERROR cycle). Then rsp_valid=1, rsp_err=1, rsp_rdata=0, rsp_wait=counter. Go to IDLE.
- Only one transfer is outstanding at a time; there is no address/data-phase overlap.
- cmd_ready is 0 in every state except IDLE.
- A command may be accepted in the same cycle rsp_valid is high.
- rsp_rdata, rsp_err and rsp_wait hold their last values until the next response.
- HRESET has priority over everything:
  - State goes to IDLE; HTRANS=IDLE.
  - cmd_ready=1 and rsp_valid=0 during the cycle after reset.
  - rsp_err=0, rsp_rdata=0, rsp_wait=0, HADDR=0, HWRITE=0, HSIZE=0, HWDATA=0.
  - An in-flight transfer is abandoned with no response; system-wide reset of the slaves is assumed.

## Timing
- Zero wait states: command accepted at edge 0 → ADDR in cycle 1 → DATA in cycle 2 → rsp_valid in cycle 3.
- Each cycle of HREADY=0 in ADDR or DATA adds one cycle of latency.
- Next command can be accepted in cycle 3, so peak throughput is one transfer per 3 cycles.
- Rejected command: rsp_valid in cycle 1.
- All AHB outputs and rsp_* outputs are registered; the only combinational path is cmd_ready from state.

## Test plan
- Reset, then read of 0x0000_0010 size 2 with HREADY=1 and HRDATA=0xDEADBEEF → HTRANS=2'b10 in cycle 1 only; rsp_valid in cycle 3 with rdata 0xDEADBEEF, err 0, wait 0.
- Write of 0x0000_0004 with wdata 0x12345678 and 3 wait states → HWDATA stable 0x12345678 through the data phase; rsp_valid in cycle 6, err 0, wait 3.
- Read with HRESP=1, HREADY=0 for one cycle, then HRESP=1, HREADY=1 → rsp_err=1, rsp_rdata=0, wait 1; exactly one response.
- Misaligned command (size 2, addr 0x2) and illegal size 3 → HTRANS never leaves IDLE; rsp_valid one cycle after accept with err 1.
- Assert HRESET during DATA with HREADY=0 → next cycle HTRANS=IDLE, rsp_valid=0, cmd_ready=1; no stale response afterwards.
- WAIT_WIDTH=2 with 6 wait states → rsp_wait=3 (saturated), err 0.
